// File: rtl/prog_loader_pkg.sv
// Shared constants for the memory program loader: FSM encodings, frame sync byte, target indices.
package prog_loader_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE = 4'd0;
    localparam state_t ST_SYNC = 4'd1;
    localparam state_t ST_TGT  = 4'd2;
    localparam state_t ST_LEN0 = 4'd3;
    localparam state_t ST_LEN1 = 4'd4;
    localparam state_t ST_DATA = 4'd5;
    localparam state_t ST_CSUM = 4'd6;
    localparam state_t ST_DONE = 4'd7;
    localparam state_t ST_ERR  = 4'd8;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam int TGT_ICCM = 0;
    localparam int TGT_DCCM = 1;

endpackage

// File: rtl/mem_prog_loader_if.sv
// Byte-stream input and memory-write/status bundle of the program loader.
// master = byte source / memory side, slave = loader.
interface mem_prog_loader_if #(
    parameter int DataWidth  = 32,
    parameter int AddrWidth  = 12,
    parameter int NumTargets = 2
);
    logic                  prog_i;
    logic                  rx_dv_i;
    logic [7:0]            rx_byte_i;
    logic [NumTargets-1:0] we_o;
    logic [AddrWidth-1:0]  addr_o;
    logic [DataWidth-1:0]  wdata_o;
    logic                  sys_rst_no;
    logic                  busy_o;
    logic                  done_o;
    logic                  err_o;

    modport master (
        output prog_i, rx_dv_i, rx_byte_i,
        input  we_o, addr_o, wdata_o, sys_rst_no, busy_o, done_o, err_o
    );

    modport slave (
        input  prog_i, rx_dv_i, rx_byte_i,
        output we_o, addr_o, wdata_o, sys_rst_no, busy_o, done_o, err_o
    );
endinterface

// File: rtl/prog_word_packer.sv
// Little-endian byte-to-word assembler; word_vld is combinational on the word's last byte.
// Latency: 0 cycles to word_vld; backpressure: none, every byte_vld is consumed.
module prog_word_packer #(
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr,
    input  logic                 byte_vld,
    input  logic [7:0]           byte_dat,
    output logic                 word_vld,
    output logic [DataWidth-1:0] word_dat
);
    localparam int Bytes = DataWidth / 8;
    localparam int CntW  = (Bytes > 1) ? $clog2(Bytes) : 1;

    logic [CntW-1:0]      cnt;
    logic [DataWidth-1:0] sr;

    // Shifting right leaves the first byte of the word in bits [7:0].
    generate
        if (Bytes > 1) begin : g_multi
            assign word_dat = {byte_dat, sr[DataWidth-1:8]};
        end else begin : g_single
            assign word_dat = byte_dat;
        end
    endgenerate

    assign word_vld = byte_vld && (cnt == CntW'(Bytes - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
            sr  <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (byte_vld) begin
            sr  <= word_dat;
            cnt <= word_vld ? '0 : cnt + CntW'(1);
        end
    end
endmodule

// File: rtl/mem_prog_loader.sv
// Framed byte-stream loader writing ICCM/DCCM words and holding system reset while loading.
// Latency: write strobe one cycle after a word's last byte; backpressure: none, source is never stalled.
module mem_prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DataWidth  = 32,
    parameter int AddrWidth  = 12,
    parameter int NumTargets = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mem_prog_loader_if.slave  bus
);
    state_t                state;
    logic [7:0]            csum;
    logic [7:0]            tgt_q;
    logic [7:0]            len_lo;
    logic [15:0]           words_left;
    logic [15:0]           len_full;
    logic [NumTargets-1:0] tgt_hot;
    logic [NumTargets-1:0] we_q;
    logic [AddrWidth-1:0]  addr_q;
    logic [DataWidth-1:0]  wdata_q;
    logic                  busy;
    logic                  len_big;
    logic                  tgt_bad;
    logic                  word_vld;
    logic [DataWidth-1:0]  word_dat;
    logic [7:0]            csum_nxt;

    assign busy     = (state == ST_SYNC) || (state == ST_TGT) || (state == ST_LEN0) ||
                      (state == ST_LEN1) || (state == ST_DATA) || (state == ST_CSUM);
    assign len_full = {bus.rx_byte_i, len_lo};
    assign len_big  = {16'd0, len_full} > (32'd1 << AddrWidth);
    assign tgt_bad  = int'(bus.rx_byte_i) >= NumTargets;
    assign csum_nxt = csum + bus.rx_byte_i;

    always_comb begin
        tgt_hot = '0;
        for (int i = 0; i < NumTargets; i++) begin
            tgt_hot[i] = (tgt_q == 8'(i));
        end
    end

    // A byte arriving with prog_i already low is dropped, never packed.
    prog_word_packer #(.DataWidth(DataWidth)) u_packer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr      (state != ST_DATA),
        .byte_vld ((state == ST_DATA) && bus.rx_dv_i && bus.prog_i),
        .byte_dat (bus.rx_byte_i),
        .word_vld (word_vld),
        .word_dat (word_dat)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            csum       <= '0;
            tgt_q      <= '0;
            len_lo     <= '0;
            words_left <= '0;
            we_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            we_q <= '0;
            if (we_q != '0) begin
                addr_q <= addr_q + AddrWidth'(1);
            end
            if (busy && !bus.prog_i) begin
                state <= ST_ERR;
            end else begin
                case (state)
                    ST_IDLE: begin
                        addr_q <= '0;
                        if (bus.prog_i) state <= ST_SYNC;
                    end
                    ST_SYNC: begin
                        csum <= '0;
                        if (bus.rx_dv_i && bus.rx_byte_i == SYNC_BYTE) state <= ST_TGT;
                    end
                    ST_TGT: if (bus.rx_dv_i) begin
                        csum  <= bus.rx_byte_i;
                        tgt_q <= bus.rx_byte_i;
                        state <= tgt_bad ? ST_ERR : ST_LEN0;
                    end
                    ST_LEN0: if (bus.rx_dv_i) begin
                        csum   <= csum_nxt;
                        len_lo <= bus.rx_byte_i;
                        state  <= ST_LEN1;
                    end
                    ST_LEN1: if (bus.rx_dv_i) begin
                        csum       <= csum_nxt;
                        words_left <= len_full;
                        if (len_big)              state <= ST_ERR;
                        else if (len_full == '0)  state <= ST_CSUM;
                        else                      state <= ST_DATA;
                    end
                    ST_DATA: if (bus.rx_dv_i) begin
                        csum <= csum_nxt;
                        if (word_vld) begin
                            we_q       <= tgt_hot;
                            wdata_q    <= word_dat;
                            words_left <= words_left - 16'd1;
                            if (words_left == 16'd1) state <= ST_CSUM;
                        end
                    end
                    ST_CSUM: if (bus.rx_dv_i) begin
                        csum  <= csum_nxt;
                        state <= (csum_nxt == 8'h00) ? ST_DONE : ST_ERR;
                    end
                    ST_DONE, ST_ERR: if (!bus.prog_i) state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.we_o       = we_q;
    assign bus.addr_o     = addr_q;
    assign bus.wdata_o    = wdata_q;
    assign bus.sys_rst_no = (state == ST_IDLE);
    assign bus.busy_o     = busy;
    assign bus.done_o     = (state == ST_DONE);
    assign bus.err_o      = (state == ST_ERR);
endmodule

// File: tb/tb_mem_prog_loader.sv
// Scenario bench for mem_prog_loader: expected writes are queued as bytes are sent
// and popped by a negedge monitor whenever a write strobe appears.
module tb_mem_prog_loader;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int NT = 2;
    localparam int BYTES = DW / 8;

    typedef struct packed {
        logic [NT-1:0] we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_prog_loader_if #(.DataWidth(DW), .AddrWidth(AW), .NumTargets(NT)) bus ();

    mem_prog_loader #(.DataWidth(DW), .AddrWidth(AW), .NumTargets(NT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    wr_t        exp_q[$];
    logic [7:0] frm[$];
    int         checks = 0;
    int         failures = 0;
    int         writes_seen = 0;

    always @(negedge clk) begin
        if (bus.we_o !== '0) begin
            wr_t e;
            writes_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got we=%b addr=%h data=%h required no write",
                         bus.we_o, bus.addr_o, bus.wdata_o);
            end else begin
                e = exp_q.pop_front();
                if ({bus.we_o, bus.addr_o, bus.wdata_o} !== e) begin
                    failures++;
                    $display("FAIL write_beat got we=%b addr=%h data=%h required we=%b addr=%h data=%h",
                             bus.we_o, bus.addr_o, bus.wdata_o, e.we, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_dv_i   = 1'b1;
        bus.rx_byte_i = b;
        @(posedge clk); #1;
        bus.rx_dv_i   = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input logic [7:0] tgt, input logic [15:0] len,
                              input logic [7:0] data[$], input logic [7:0] delta,
                              input bit push);
        logic [7:0]    sum;
        logic [DW-1:0] word;
        logic [NT-1:0] oh;
        word = '0;
        oh   = NT'(1) << tgt;
        sum  = tgt + len[7:0] + len[15:8];
        send_byte(8'hA5);
        send_byte(tgt);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        for (int i = 0; i < data.size(); i++) begin
            sum  = sum + data[i];
            word = {data[i], word[DW-1:8]};
            if (push && (i % BYTES == BYTES - 1))
                exp_q.push_back('{we: oh, addr: AW'(i / BYTES), data: word});
            send_byte(data[i]);
        end
        send_byte(8'(8'd0 - sum + delta));
    endtask

    task automatic load_ab();
        logic [63:0] pat;
        pat = 64'hDEADBEEF_12345678;
        frm.delete();
        for (int i = 0; i < 8; i++) frm.push_back(pat[i*8 +: 8]);
    endtask

    task automatic start_prog();
        bus.prog_i = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic end_prog();
        bus.prog_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.prog_i = 1'b0; bus.rx_dv_i = 1'b0; bus.rx_byte_i = 8'h00;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.we_o, bus.addr_o, bus.wdata_o, bus.busy_o, bus.done_o, bus.err_o, bus.sys_rst_no}
            !== {{NT{1'b0}}, {AW{1'b0}}, {DW{1'b0}}, 4'b0001}) begin
            failures++;
            $display("FAIL reset_values got we=%b addr=%h wdata=%h busy/done/err/srst=%b required all zero, srst=1",
                     bus.we_o, bus.addr_o, bus.wdata_o,
                     {bus.busy_o, bus.done_o, bus.err_o, bus.sys_rst_no});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bus.busy_o, bus.done_o, bus.err_o, bus.sys_rst_no} !== 4'b0001) begin
            failures++;
            $display("FAIL idle_after_reset got busy/done/err/srst=%b required 0001",
                     {bus.busy_o, bus.done_o, bus.err_o, bus.sys_rst_no});
        end
    endtask

    task automatic test_iccm();
        int w0;
        w0 = writes_seen;
        load_ab();
        start_prog();
        checks++;
        if ({bus.busy_o, bus.sys_rst_no} !== 2'b10) begin
            failures++;
            $display("FAIL sync_entry got busy/srst=%b required 10", {bus.busy_o, bus.sys_rst_no});
        end
        send_byte(8'h00);
        send_byte(8'h5A);
        send_frame(8'd0, 16'd2, frm, 8'd0, 1'b1);
        checks++;
        if ({bus.done_o, bus.err_o, bus.busy_o} !== 3'b100) begin
            failures++;
            $display("FAIL iccm_done got done/err/busy=%b required 100",
                     {bus.done_o, bus.err_o, bus.busy_o});
        end
        checks++;
        if (writes_seen - w0 != 2 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL iccm_writes got %0d writes, %0d pending required 2 writes, 0 pending",
                     writes_seen - w0, exp_q.size());
        end
        end_prog();
        checks++;
        if ({bus.done_o, bus.sys_rst_no} !== 2'b01) begin
            failures++;
            $display("FAIL iccm_release got done/srst=%b required 01", {bus.done_o, bus.sys_rst_no});
        end
    endtask

    task automatic test_dccm();
        int w0;
        w0 = writes_seen;
        load_ab();
        start_prog();
        send_frame(8'd1, 16'd2, frm, 8'd0, 1'b1);
        checks++;
        if (bus.done_o !== 1'b1 || writes_seen - w0 != 2) begin
            failures++;
            $display("FAIL dccm_frame got done=%b writes=%0d required done=1 writes=2",
                     bus.done_o, writes_seen - w0);
        end
        end_prog();
    endtask

    task automatic test_bad_target();
        int w0;
        w0 = writes_seen;
        load_ab();
        start_prog();
        send_frame(8'd5, 16'd2, frm, 8'd0, 1'b0);
        checks++;
        if ({bus.err_o, bus.done_o} !== 2'b10 || writes_seen != w0) begin
            failures++;
            $display("FAIL bad_target got err/done=%b writes=%0d required err/done=10 writes=0",
                     {bus.err_o, bus.done_o}, writes_seen - w0);
        end
        end_prog();
    endtask

    task automatic test_bad_csum();
        int w0;
        w0 = writes_seen;
        load_ab();
        start_prog();
        send_frame(8'd0, 16'd2, frm, 8'd1, 1'b1);
        checks++;
        if ({bus.err_o, bus.done_o} !== 2'b10 || writes_seen - w0 != 2) begin
            failures++;
            $display("FAIL bad_csum got err/done=%b writes=%0d required err/done=10 writes=2",
                     {bus.err_o, bus.done_o}, writes_seen - w0);
        end
        end_prog();
    endtask

    task automatic test_len_zero();
        int w0;
        w0 = writes_seen;
        frm.delete();
        start_prog();
        send_frame(8'd0, 16'd0, frm, 8'd0, 1'b0);
        checks++;
        if ({bus.done_o, bus.err_o} !== 2'b10 || writes_seen != w0) begin
            failures++;
            $display("FAIL len_zero got done/err=%b writes=%0d required done/err=10 writes=0",
                     {bus.done_o, bus.err_o}, writes_seen - w0);
        end
        end_prog();
    endtask

    task automatic test_len_too_big();
        start_prog();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h10);
        checks++;
        if (bus.err_o !== 1'b1) begin
            failures++;
            $display("FAIL len_4097 got err=%b required 1", bus.err_o);
        end
        end_prog();
    endtask

    task automatic abort_prefix();
        load_ab();
        start_prog();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 3; i++) send_byte(frm[i]);
    endtask

    task automatic test_abort();
        int w0;
        w0 = writes_seen;
        abort_prefix();
        bus.prog_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bus.err_o, bus.sys_rst_no} !== 2'b10) begin
            failures++;
            $display("FAIL abort_err got err/srst=%b required 10", {bus.err_o, bus.sys_rst_no});
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.err_o, bus.busy_o, bus.sys_rst_no} !== 3'b001 || writes_seen != w0) begin
            failures++;
            $display("FAIL abort_idle got err/busy/srst=%b writes=%0d required 001 writes=0",
                     {bus.err_o, bus.busy_o, bus.sys_rst_no}, writes_seen - w0);
        end
    endtask

    task automatic test_drop_priority();
        int w0;
        w0 = writes_seen;
        abort_prefix();
        bus.prog_i    = 1'b0;
        bus.rx_dv_i   = 1'b1;
        bus.rx_byte_i = frm[3];
        @(posedge clk); #1;
        bus.rx_dv_i = 1'b0;
        checks++;
        if (bus.err_o !== 1'b1) begin
            failures++;
            $display("FAIL drop_prio_err got err=%b required 1", bus.err_o);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (writes_seen != w0 || bus.sys_rst_no !== 1'b1) begin
            failures++;
            $display("FAIL drop_prio_nowrite got writes=%0d srst=%b required writes=0 srst=1",
                     writes_seen - w0, bus.sys_rst_no);
        end
    endtask

    task automatic test_reset_midframe();
        int w0;
        w0 = writes_seen;
        abort_prefix();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.we_o, bus.wdata_o, bus.busy_o, bus.err_o, bus.sys_rst_no}
            !== {{NT{1'b0}}, {DW{1'b0}}, 3'b001}) begin
            failures++;
            $display("FAIL midframe_reset got we=%b wdata=%h busy/err/srst=%b required 0, 0, 001",
                     bus.we_o, bus.wdata_o, {bus.busy_o, bus.err_o, bus.sys_rst_no});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        send_byte(frm[3]);
        send_byte(frm[4]);
        checks++;
        if (writes_seen != w0) begin
            failures++;
            $display("FAIL midframe_nowrite got writes=%0d required 0", writes_seen - w0);
        end
        end_prog();
    endtask

    task automatic test_back_to_back();
        int w0;
        w0 = writes_seen;
        load_ab();
        start_prog();
        send_frame(8'd0, 16'd2, frm, 8'd0, 1'b1);
        end_prog();
        frm.delete();
        for (int i = 0; i < 16; i++) frm.push_back(8'(i * 17 + 3));
        start_prog();
        send_frame(8'd1, 16'd4, frm, 8'd0, 1'b1);
        checks++;
        if (bus.done_o !== 1'b1 || writes_seen - w0 != 6 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL back_to_back got done=%b writes=%0d pending=%0d required done=1 writes=6 pending=0",
                     bus.done_o, writes_seen - w0, exp_q.size());
        end
        end_prog();
    endtask

    initial begin
        test_reset();
        test_iccm();
        test_dccm();
        test_bad_target();
        test_bad_csum();
        test_len_zero();
        test_len_too_big();
        test_abort();
        test_drop_priority();
        test_reset_midframe();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
